// File: rtl/mem_arbiter_pkg.sv
// Shared memory-arbiter definitions: FSM state encoding,
// requester ids and default line address/data widths.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 28;
    localparam int unsigned DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of I-cache, D-cache and shared memory signals.
// slave: arbiter view. master: caches + memory view.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              I_mem_read;
    logic              I_mem_write;
    logic [ADDR_W-1:0] I_mem_addr;
    logic [DATA_W-1:0] I_mem_wdata;
    logic              I_mem_ready;
    logic [DATA_W-1:0] I_mem_rdata;

    logic              D_mem_read;
    logic              D_mem_write;
    logic [ADDR_W-1:0] D_mem_addr;
    logic [DATA_W-1:0] D_mem_wdata;
    logic              D_mem_ready;
    logic [DATA_W-1:0] D_mem_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  I_mem_read, I_mem_write,
        input  I_mem_addr, I_mem_wdata,
        output I_mem_ready, I_mem_rdata,
        input  D_mem_read, D_mem_write,
        input  D_mem_addr, D_mem_wdata,
        output D_mem_ready, D_mem_rdata,
        output mem_read, mem_write,
        output mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport master (
        output I_mem_read, I_mem_write,
        output I_mem_addr, I_mem_wdata,
        input  I_mem_ready, I_mem_rdata,
        output D_mem_read, D_mem_write,
        output D_mem_addr, D_mem_wdata,
        input  D_mem_ready, D_mem_rdata,
        input  mem_read, mem_write,
        input  mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/arb_grant_sel.sv
// Combinational I/D grant picker. Ports: req_i, req_d,
// last_grant (1 = D granted last) -> grant_d. Macro: ARB_ROUND_ROBIN_EN.
module arb_grant_sel (
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant_d
);

`ifdef ARB_ROUND_ROBIN_EN
    // On a collision, D wins only if it was not granted last.
    assign grant_d = req_d & (~req_i | ~last_grant);
`else
    logic unused_last;
    assign unused_last = last_grant;
    // Fixed priority: D always wins a collision.
    assign grant_d = req_d;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// I/D cache to single memory port arbiter (IDLE/BUSY/DONE).
// Ports: clk, rst_n, bus (mem_arbiter_if.slave). Macro: ARB_ROUND_ROBIN_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    arb_state_e        state_q;
    arb_port_e         owner_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              i_ready_q;
    logic              d_ready_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic              req_i;
    logic              req_d;
    logic              pick_d;
    logic              last_grant;
    logic              mem_read_d;
    logic              mem_write_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;

    assign req_i = bus.I_mem_read | bus.I_mem_write;
    assign req_d = bus.D_mem_read | bus.D_mem_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q;
    assign last_grant = last_d_q;
`else
    assign last_grant = 1'b0;
`endif

    arb_grant_sel u_grant_sel (
        .req_i      (req_i),
        .req_d      (req_d),
        .last_grant (last_grant),
        .grant_d    (pick_d)
    );

    // Request payload of whichever port wins; read+write is a write.
    always_comb begin
        mem_write_d = bus.I_mem_write;
        mem_read_d  = bus.I_mem_read;
        mem_addr_d  = bus.I_mem_addr;
        mem_wdata_d = bus.I_mem_wdata;
        if (pick_d) begin
            mem_write_d = bus.D_mem_write;
            mem_read_d  = bus.D_mem_read;
            mem_addr_d  = bus.D_mem_addr;
            mem_wdata_d = bus.D_mem_wdata;
        end
        mem_read_d = mem_read_d & ~mem_write_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= PORT_I;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_i || req_d) begin
                        mem_read_q  <= mem_read_d;
                        mem_write_q <= mem_write_d;
                        mem_addr_q  <= mem_addr_d;
                        mem_wdata_q <= mem_wdata_d;
                        owner_q     <= pick_d ? PORT_D : PORT_I;
                        state_q     <= BUSY;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d_q    <= pick_d;
`endif
                    end
                end
                BUSY: begin
                    if (bus.mem_ready) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= DONE;
                        // Write completions leave the read data untouched.
                        if (owner_q == PORT_D) begin
                            d_ready_q <= 1'b1;
                            if (!mem_write_q) d_rdata_q <= bus.mem_rdata;
                        end else begin
                            i_ready_q <= 1'b1;
                            if (!mem_write_q) i_rdata_q <= bus.mem_rdata;
                        end
                    end
                end
                DONE: begin
                    // No grant here so the finishing port can drop its request.
                    i_ready_q <= 1'b0;
                    d_ready_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.I_mem_ready = i_ready_q;
    assign bus.I_mem_rdata = i_rdata_q;
    assign bus.D_mem_ready = d_ready_q;
    assign bus.D_mem_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cases plus random traffic
// checked every cycle against a transaction-level model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 28;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- model ----------------
    logic          e_rd = 1'b0;
    logic          e_wr = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;
    logic          e_ir = 1'b0;
    logic          e_dr = 1'b0;
    logic [DW-1:0] e_irdata = '0;
    logic [DW-1:0] e_drdata = '0;
    bit            m_busy = 1'b0;
    bit            m_done = 1'b0;
    bit            m_own_d = 1'b0;
    bit            m_last_d = 1'b0;

    function automatic bit pick_d(bit ir, bit dr, bit last_d);
        if (!ir) return 1'b1;
        if (!dr) return 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        return !last_d;
`else
        return 1'b1 | last_d;
`endif
    endfunction

    // One outstanding memory transaction at a time; one quiet
    // cycle with the ready pulse after it completes.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_rd <= 0; e_wr <= 0; e_addr <= '0; e_wdata <= '0;
            e_ir <= 0; e_dr <= 0; e_irdata <= '0; e_drdata <= '0;
            m_busy <= 0; m_done <= 0; m_own_d <= 0; m_last_d <= 0;
        end else if (m_done) begin
            e_ir <= 0; e_dr <= 0; m_done <= 0;
        end else if (m_busy) begin
            if (bus.mem_ready) begin
                m_busy <= 0; m_done <= 1;
                e_rd <= 0; e_wr <= 0;
                if (m_own_d) begin
                    e_dr <= 1;
                    if (!e_wr) e_drdata <= bus.mem_rdata;
                end else begin
                    e_ir <= 1;
                    if (!e_wr) e_irdata <= bus.mem_rdata;
                end
            end
        end else if ((bus.I_mem_read | bus.I_mem_write) ||
                     (bus.D_mem_read | bus.D_mem_write)) begin
            if (pick_d(bus.I_mem_read | bus.I_mem_write,
                       bus.D_mem_read | bus.D_mem_write, m_last_d)) begin
                e_wr <= bus.D_mem_write;
                e_rd <= bus.D_mem_read & ~bus.D_mem_write;
                e_addr <= bus.D_mem_addr;
                e_wdata <= bus.D_mem_wdata;
                m_own_d <= 1; m_last_d <= 1;
            end else begin
                e_wr <= bus.I_mem_write;
                e_rd <= bus.I_mem_read & ~bus.I_mem_write;
                e_addr <= bus.I_mem_addr;
                e_wdata <= bus.I_mem_wdata;
                m_own_d <= 0; m_last_d <= 0;
            end
            m_busy <= 1;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(string nm, logic [DW-1:0] act,
                       logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cmp_model();
        chk("m.mem_read", DW'(bus.mem_read), DW'(e_rd));
        chk("m.mem_write", DW'(bus.mem_write), DW'(e_wr));
        chk("m.mem_addr", DW'(bus.mem_addr), DW'(e_addr));
        chk("m.mem_wdata", bus.mem_wdata, e_wdata);
        chk("m.I_ready", DW'(bus.I_mem_ready), DW'(e_ir));
        chk("m.D_ready", DW'(bus.D_mem_ready), DW'(e_dr));
        chk("m.I_rdata", bus.I_mem_rdata, e_irdata);
        chk("m.D_rdata", bus.D_mem_rdata, e_drdata);
    endtask

    task automatic step();
        @(negedge clk);
        if (rst_n) cmp_model();
    endtask

    task automatic chk_all_zero(string nm);
        chk({nm, ".mem_read"}, DW'(bus.mem_read), '0);
        chk({nm, ".mem_write"}, DW'(bus.mem_write), '0);
        chk({nm, ".mem_addr"}, DW'(bus.mem_addr), '0);
        chk({nm, ".mem_wdata"}, bus.mem_wdata, '0);
        chk({nm, ".I_ready"}, DW'(bus.I_mem_ready), '0);
        chk({nm, ".D_ready"}, DW'(bus.D_mem_ready), '0);
        chk({nm, ".I_rdata"}, bus.I_mem_rdata, '0);
        chk({nm, ".D_rdata"}, bus.D_mem_rdata, '0);
    endtask

    // ---------------- random agents ----------------
    bit i_pend = 0, d_pend = 0;
    int i_iss = 0, i_done = 0, d_iss = 0, d_done = 0;
    int resp_wait = -1;

    task automatic agents(bit issue);
        int rw;
        if (i_pend && bus.I_mem_ready) begin
            i_pend = 0; i_done++;
            bus.I_mem_read = 0; bus.I_mem_write = 0;
        end
        if (issue && !i_pend && $urandom_range(0, 3) == 0) begin
            i_pend = 1; i_iss++;
            rw = $urandom_range(0, 3);
            bus.I_mem_read  = (rw != 1);
            bus.I_mem_write = (rw == 1 || rw == 2);
            bus.I_mem_addr  = AW'($urandom);
            bus.I_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
        end
        if (d_pend && bus.D_mem_ready) begin
            d_pend = 0; d_done++;
            bus.D_mem_read = 0; bus.D_mem_write = 0;
        end
        if (issue && !d_pend && $urandom_range(0, 2) == 0) begin
            d_pend = 1; d_iss++;
            rw = $urandom_range(0, 3);
            bus.D_mem_read  = (rw != 1);
            bus.D_mem_write = (rw == 1 || rw == 2);
            bus.D_mem_addr  = AW'($urandom);
            bus.D_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
        end
        // memory: 0..3 cycle latency, plus stray ready pulses when idle
        if (bus.mem_ready) begin
            bus.mem_ready = 0;
        end else if (bus.mem_read || bus.mem_write) begin
            if (resp_wait < 0) resp_wait = $urandom_range(0, 3);
            if (resp_wait == 0) begin
                bus.mem_ready = 1;
                bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                resp_wait = -1;
            end else begin
                resp_wait--;
            end
        end else if ($urandom_range(0, 7) == 0) begin
            bus.mem_ready = 1;
            bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // ---------------- directed + random ----------------
    localparam logic [DW-1:0] L1 =
        128'h01234567_89abcdef_00112233_44556677;
    localparam logic [DW-1:0] WD =
        128'hDEADBEEF_00000000_00000000_00000001;

    initial begin
        logic [DW-1:0] d_last;
        logic [DW-1:0] lk;
        bit exp_d[3];
        bus.I_mem_read = 0; bus.I_mem_write = 0;
        bus.I_mem_addr = '0; bus.I_mem_wdata = '0;
        bus.D_mem_read = 0; bus.D_mem_write = 0;
        bus.D_mem_addr = '0; bus.D_mem_wdata = '0;
        bus.mem_ready = 0; bus.mem_rdata = '0;

        // reset holds everything at zero despite active inputs
        repeat (2) step();
        bus.I_mem_read = 1; bus.I_mem_addr = AW'(28'h0000010);
        bus.D_mem_write = 1; bus.mem_ready = 1;
        step();
        chk_all_zero("rst");

        // single I read; grant on the first edge after reset
        bus.D_mem_write = 0; bus.mem_ready = 0;
        rst_n = 1;
        step();
        chk("t1.mem_read", DW'(bus.mem_read), DW'(1));
        chk("t1.mem_addr", DW'(bus.mem_addr), DW'(28'h10));
        repeat (3) step();
        bus.mem_ready = 1; bus.mem_rdata = L1;
        step();
        chk("t1.I_ready", DW'(bus.I_mem_ready), DW'(1));
        chk("t1.I_rdata", bus.I_mem_rdata, L1);
        chk("t1.D_ready", DW'(bus.D_mem_ready), DW'(0));
        chk("t1.mem_read_off", DW'(bus.mem_read), DW'(0));
        bus.mem_ready = 0; bus.I_mem_read = 0;
        step();
        chk("t1.I_ready_pulse", DW'(bus.I_mem_ready), DW'(0));
        chk("t1.I_rdata_hold", bus.I_mem_rdata, L1);

        // read+write together is a write
        bus.I_mem_read = 1; bus.I_mem_write = 1;
        bus.I_mem_addr = AW'(28'h20); bus.I_mem_wdata = ~L1;
        step();
        chk("t2.mem_write", DW'(bus.mem_write), DW'(1));
        chk("t2.mem_read", DW'(bus.mem_read), DW'(0));
        bus.mem_ready = 1; bus.mem_rdata = '1;
        step();
        chk("t2.I_ready", DW'(bus.I_mem_ready), DW'(1));
        bus.mem_ready = 0; bus.I_mem_read = 0; bus.I_mem_write = 0;
        step();

        // stray mem_ready while idle
        bus.mem_ready = 1; bus.mem_rdata = ~L1;
        step();
        chk("t3.I_ready", DW'(bus.I_mem_ready), DW'(0));
        chk("t3.D_ready", DW'(bus.D_mem_ready), DW'(0));
        chk("t3.mem_read", DW'(bus.mem_read), DW'(0));
        bus.mem_ready = 0;

        // back-to-back collisions
`ifdef ARB_ROUND_ROBIN_EN
        exp_d = '{1'b1, 1'b0, 1'b1};
`else
        exp_d = '{1'b1, 1'b1, 1'b1};
`endif
        bus.I_mem_read = 1; bus.I_mem_addr = AW'(28'h111);
        bus.D_mem_read = 1; bus.D_mem_addr = AW'(28'h222);
        d_last = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4.grant_addr", DW'(bus.mem_addr),
                exp_d[k] ? DW'(28'h222) : DW'(28'h111));
            lk = {96'h0, 32'(k + 5)};
            bus.mem_ready = 1; bus.mem_rdata = lk;
            step();
            chk("t4.D_ready", DW'(bus.D_mem_ready), DW'(exp_d[k]));
            chk("t4.I_ready", DW'(bus.I_mem_ready), DW'(!exp_d[k]));
            if (exp_d[k]) d_last = lk;
            bus.mem_ready = 0;
            step();
        end
        bus.I_mem_read = 0; bus.D_mem_read = 0;

        // D write: payload steady through BUSY, read data untouched
        bus.D_mem_write = 1; bus.D_mem_addr = AW'(28'h000ABCD);
        bus.D_mem_wdata = WD;
        step();
        for (int c = 0; c < 4; c++) begin
            chk("t5.mem_write", DW'(bus.mem_write), DW'(1));
            chk("t5.mem_wdata", bus.mem_wdata, WD);
            chk("t5.mem_addr", DW'(bus.mem_addr), DW'(28'hABCD));
            if (c < 3) step();
        end
        bus.mem_ready = 1; bus.mem_rdata = ~L1;
        step();
        chk("t5.D_ready", DW'(bus.D_mem_ready), DW'(1));
        chk("t5.D_rdata", bus.D_mem_rdata, d_last);
        bus.D_mem_write = 0;
        step();
        chk("t5.D_ready_pulse", DW'(bus.D_mem_ready), DW'(0));
        bus.mem_ready = 0;
        step();

        // reset in the middle of BUSY
        bus.I_mem_read = 1; bus.I_mem_addr = AW'(28'h333);
        step();
        chk("t6.mem_read", DW'(bus.mem_read), DW'(1));
        #2 rst_n = 0;
        #1 chk_all_zero("t6.async");
        repeat (2) step();
        chk("t6.no_ready", DW'(bus.I_mem_ready), DW'(0));
        rst_n = 1;
        step();
        chk("t6.regrant", DW'(bus.mem_read), DW'(1));
        chk("t6.addr", DW'(bus.mem_addr), DW'(28'h333));
        bus.mem_ready = 1; bus.mem_rdata = L1;
        step();
        chk("t6.I_ready", DW'(bus.I_mem_ready), DW'(1));
        bus.mem_ready = 0; bus.I_mem_read = 0;
        step();

        // random traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            agents(1'b1);
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            step();
            agents(1'b0);
            if (!i_pend && !d_pend) break;
        end
        chk("rnd.I_served", DW'(i_done), DW'(i_iss));
        chk("rnd.D_served", DW'(d_done), DW'(d_iss));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
